// File: rtl/ws2811_tx_if.sv
// rtl/ws2811_tx_if.sv - pixel word valid/ready handshake for ws2811_tx
interface ws2811_tx_if;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ws2811_tx.sv
// rtl/ws2811_tx.sv - WS2811/WS2812 NRZ serializer, GRB MSB first, one-word holding register
// Defining WS2811_PIXCNT_EN adds the per-frame pix_count output.
module ws2811_tx #(
    parameter int BIT_CYCLES   = 20,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 10,
    parameter int RESET_CYCLES = 800
) (
    input  logic        CLK,
    input  logic        RST,
    ws2811_tx_if.slave  pix,
    output logic        DOUT,
    output logic        busy
`ifdef WS2811_PIXCNT_EN
    ,
    output logic [15:0] pix_count
`endif
);

    localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] T0H        = 16'(T0H_CYCLES);
    localparam logic [15:0] T1H        = 16'(T1H_CYCLES);
    localparam logic [15:0] LATCH_LAST = (RESET_CYCLES == 0) ? 16'd0 : 16'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_LATCH
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [4:0]  bit_idx, bit_idx_n;
    logic [23:0] shifter, shifter_n;
    logic [23:0] hold, hold_n;
    logic        hold_valid, hold_valid_n;
    logic        dout_n;
    logic        load;
    logic        accept;
    logic [15:0] th_n;

    assign pix.in_ready = !hold_valid;
    assign accept       = pix.in_valid && !hold_valid;
    assign busy         = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_LATCH;
            cnt        <= '0;
            bit_idx    <= '0;
            shifter    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            DOUT       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shifter    <= shifter_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
            DOUT       <= dout_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_idx_n = bit_idx;
        shifter_n = shifter;
        load      = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (hold_valid) begin
                    load    = 1'b1;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (bit_idx != 5'd0) begin
                        bit_idx_n = bit_idx - 5'd1;
                        shifter_n = {shifter[22:0], 1'b0};
                    end else if (hold_valid) begin
                        load = 1'b1;
                    end else begin
                        state_n = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                // The latch always runs to completion, even with a word waiting.
                if (cnt == LATCH_LAST) begin
                    cnt_n = '0;
                    if (hold_valid) begin
                        load    = 1'b1;
                        state_n = S_SEND;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_LATCH;
                cnt_n   = '0;
            end
        endcase

        if (load) begin
            shifter_n = hold;
            bit_idx_n = 5'd23;
        end

        hold_n       = accept ? pix.in_data : hold;
        hold_valid_n = load ? 1'b0 : (accept ? 1'b1 : hold_valid);

        // DOUT is registered, so it is computed from the bit and count of the coming cycle.
        th_n   = shifter_n[23] ? T1H : T0H;
        dout_n = (state_n == S_SEND) && (cnt_n < th_n);
    end

`ifdef WS2811_PIXCNT_EN
    logic        leave_latch;
    logic [15:0] pix_base;
    logic [15:0] pix_count_n;

    assign leave_latch = (state == S_LATCH) && (cnt == LATCH_LAST);

    always_comb begin
        pix_base    = leave_latch ? 16'd0 : pix_count;
        pix_count_n = (load && (pix_base != 16'hFFFF)) ? pix_base + 16'd1 : pix_base;
    end

    always_ff @(posedge CLK) begin
        if (RST) pix_count <= '0;
        else     pix_count <= pix_count_n;
    end
`endif

endmodule

// File: tb/tb_ws2811_tx.sv
// tb/tb_ws2811_tx.sv - randomized self-checking bench for ws2811_tx against a schedule model
`timescale 1ns/1ps
module tb_ws2811_tx;
    localparam int BC  = 20;
    localparam int T0H = 4;
    localparam int T1H = 10;
    localparam int RC  = 800;
    localparam int PIX = 24 * BC;
`ifdef WS2811_PIXCNT_EN
    localparam int NSIG = 4;
`else
    localparam int NSIG = 3;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic DOUT;
    logic busy;
`ifdef WS2811_PIXCNT_EN
    logic [15:0] pix_count;
`endif

    ws2811_tx_if pix();

    ws2811_tx #(
        .BIT_CYCLES(BC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .RESET_CYCLES(RC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .pix(pix),
        .DOUT(DOUT),
        .busy(busy)
`ifdef WS2811_PIXCNT_EN
        ,
        .pix_count(pix_count)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;
    int r_cyc  = 0;

    // Per-cycle observations, index 0 = the cycle right after the last reset edge.
    logic        tr_d[$];
    logic        tr_b[$];
    logic        tr_r[$];
    logic [15:0] tr_p[$];
    int          acc_t[$];
    logic [23:0] acc_w[$];
    logic [23:0] tx_q[$];
    int          tx_t[$];
    logic        pres_v = 1'b0;
    logic        pres_r = 1'b0;
    logic [23:0] pres_d = '0;
    string       sn[4] = '{"dout", "busy", "in_ready", "pix_count"};

    task automatic observe();
        tr_d.push_back(DOUT);
        tr_b.push_back(busy);
        tr_r.push_back(pix.in_ready);
`ifdef WS2811_PIXCNT_EN
        tr_p.push_back(pix_count);
`else
        tr_p.push_back(16'd0);
`endif
    endtask

    // Word is presented only when the DUT is ready; otherwise in_data carries noise.
    task automatic present();
        int rel;
        rel = cyc - r_cyc;
        if (pres_v && pres_r) begin
            acc_t.push_back(rel);
            acc_w.push_back(pres_d);
            void'(tx_q.pop_front());
            void'(tx_t.pop_front());
        end
        if (tx_q.size() > 0 && rel >= tx_t[0]) begin
            pix.in_valid = 1'b1;
            pix.in_data  = pix.in_ready ? tx_q[0] : 24'($urandom);
        end else begin
            pix.in_valid = 1'b0;
            pix.in_data  = 24'($urandom);
        end
        pres_v = pix.in_valid;
        pres_d = pix.in_data;
        pres_r = pix.in_ready;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge CLK);
            observe();
            present();
        end
    endtask

    task automatic do_reset(output logic pre_d, output logic post_d);
        @(negedge CLK);
        pre_d = DOUT;
        RST = 1'b1;
        pix.in_valid = 1'b0;
        pres_v = 1'b0;
        @(negedge CLK);
        post_d = DOUT;
        @(negedge CLK);
        RST = 1'b0;
        r_cyc = cyc;
        tr_d.delete(); tr_b.delete(); tr_r.delete(); tr_p.delete();
        acc_t.delete(); acc_w.delete();
        observe();
        present();
    endtask

    function automatic int first_high(input int from);
        for (int i = from; i < tr_d.size(); i++)
            if (tr_d[i] === 1'b1) return i;
        return -1;
    endfunction

    // Pixel start times follow from accept times: continue if accepted before the
    // previous pixel ends, otherwise after the latch, otherwise one cycle after accept.
    task automatic check_model(input string name);
        int s[$];
        int lat_lo[$];
        int lat_hi[$];
        int prev_e, lend, st, c, last_clr, xp;
        logic [23:0] w;
        logic xd, xb, xr;
        logic [15:0] got[4];
        logic [15:0] want[4];
        int err[4], ft[4];
        logic [15:0] fg[4], fw[4];

        prev_e = -1;
        lat_lo.push_back(0);
        lat_hi.push_back(RC);
        foreach (acc_t[i]) begin
            if (prev_e < 0) begin
                st = (acc_t[i] < RC) ? RC : acc_t[i] + 1;
            end else if (acc_t[i] < prev_e) begin
                st = prev_e;
            end else begin
                lend = prev_e + RC;
                lat_lo.push_back(prev_e);
                lat_hi.push_back(lend);
                st = (acc_t[i] < lend) ? lend : acc_t[i] + 1;
            end
            s.push_back(st);
            prev_e = st + PIX;
        end
        if (prev_e >= 0) begin
            lat_lo.push_back(prev_e);
            lat_hi.push_back(prev_e + RC);
        end

        for (int k = 0; k < 4; k++) begin err[k] = 0; ft[k] = 0; fg[k] = 0; fw[k] = 0; end
        for (int t = 0; t < tr_d.size(); t++) begin
            xd = 1'b0; xb = 1'b0; xr = 1'b1; xp = 0; last_clr = 0;
            foreach (s[i]) begin
                if (t >= s[i] && t < s[i] + PIX) begin
                    xb = 1'b1;
                    c  = t - s[i];
                    w  = acc_w[i];
                    xd = ((c % BC) < (w[23 - c / BC] ? T1H : T0H));
                end
                if (t >= acc_t[i] && t < s[i]) xr = 1'b0;
            end
            foreach (lat_lo[j]) begin
                if (t >= lat_lo[j] && t < lat_hi[j]) xb = 1'b1;
                if (lat_hi[j] <= t && lat_hi[j] > last_clr) last_clr = lat_hi[j];
            end
            foreach (s[i]) if (s[i] >= last_clr && s[i] <= t) xp++;
            if (xp > 65535) xp = 65535;
            got[0] = {15'd0, tr_d[t]}; want[0] = {15'd0, xd};
            got[1] = {15'd0, tr_b[t]}; want[1] = {15'd0, xb};
            got[2] = {15'd0, tr_r[t]}; want[2] = {15'd0, xr};
            got[3] = tr_p[t];          want[3] = 16'(xp);
            for (int k = 0; k < NSIG; k++) begin
                if (got[k] !== want[k]) begin
                    if (err[k] == 0) begin ft[k] = t; fg[k] = got[k]; fw[k] = want[k]; end
                    err[k]++;
                end
            end
        end
        for (int k = 0; k < NSIG; k++) begin
            n_chk++;
            if (err[k] !== 0)
                $display("FAIL %s_%s: %0d cycles differ, first at cycle %0d got %0d want %0d",
                         name, sn[k], err[k], ft[k], fg[k], fw[k]);
            else n_pass++;
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_chk++;
        if (got !== want) $display("FAIL %s: got %0d want %0d", name, got, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic pd, qd;
        int hi, bad_d, bad_r;
        do_reset(pd, qd);
        check_int("reset_dout", int'(tr_d[0]), 0);
        check_int("reset_busy", int'(tr_b[0]), 1);
        check_int("reset_ready", int'(tr_r[0]), 1);
`ifdef WS2811_PIXCNT_EN
        check_int("reset_pix_count", int'(tr_p[0]), 0);
`endif
        run(850);
        hi = 0;
        while (hi < tr_b.size() && tr_b[hi] === 1'b1) hi++;
        check_int("reset_busy_len", hi, 800);
        bad_d = 0; bad_r = 0;
        foreach (tr_d[i]) begin
            if (tr_d[i] !== 1'b0) bad_d++;
            if (tr_r[i] !== 1'b1) bad_r++;
        end
        check_int("reset_dout_low_cycles_bad", bad_d, 0);
        check_int("reset_ready_high_cycles_bad", bad_r, 0);
        check_model("reset");
    endtask

    task automatic test_single_pixel();
        logic pd, qd;
        int rise, bad, lo, hi;
        do_reset(pd, qd);
        run(849);
        tx_q.push_back(24'hFF0000); tx_t.push_back(850);
        run(1400);
        check_int("single_accepts", acc_t.size(), 1);
        rise = first_high(0);
        check_int("single_latency", rise - (acc_t.size() > 0 ? acc_t[0] : -99), 1);
        bad = 0; hi = 0;
        if (rise < 0 || rise + PIX + RC >= tr_d.size()) begin
            bad = 1;
        end else begin
            for (int b = 0; b < 24; b++)
                for (int k = 0; k < BC; k++)
                    if (tr_d[rise + b * BC + k] !== ((k < (b < 8 ? 10 : 4)) ? 1'b1 : 1'b0)) bad++;
            lo = rise + PIX;
            while (lo + hi < tr_b.size() && tr_b[lo + hi] === 1'b1) begin
                if (tr_d[lo + hi] !== 1'b0) bad++;
                hi++;
            end
        end
        check_int("single_bit_shape_bad", bad, 0);
        check_int("single_latch_len", hi, 800);
        check_model("single");
    endtask

    task automatic test_back_to_back();
        logic pd, qd;
        int hi, gaps;
        tx_q = '{24'hAAAAAA, 24'h555555, 24'h000001};
        tx_t = '{0, 0, 0};
        do_reset(pd, qd);
        run(3200);
        check_int("b2b_accepts", acc_t.size(), 3);
        hi = 0;
        while (hi < tr_b.size() && tr_b[hi] === 1'b1) hi++;
        check_int("b2b_busy_span", hi, RC + 3 * PIX + RC);
        gaps = 0;
        for (int b = 0; b < 72; b++) if (tr_d[RC + b * BC] !== 1'b1) gaps++;
        check_int("b2b_bit_starts_missing", gaps, 0);
        check_model("b2b");
    endtask

    task automatic test_accept_during_latch();
        logic pd, qd;
        tx_q = '{24'($urandom), 24'h123456};
        tx_t = '{0, RC + PIX + 199};
        do_reset(pd, qd);
        run(2700);
        check_int("latch_accepts", acc_t.size(), 2);
        check_int("latch_accept_cycle", (acc_t.size() > 1) ? acc_t[1] : -1, RC + PIX + 200);
        check_int("latch_tx_start", first_high(RC + PIX + 1), RC + PIX + RC);
        check_model("latch_accept");
    endtask

    task automatic test_reset_mid_pixel();
        logic pd, qd;
        tx_q = '{24'hFFFFFF, 24'($urandom)};
        tx_t = '{0, 0};
        do_reset(pd, qd);
        run(1004);
        check_int("mid_buffered", acc_t.size(), 2);
        check_model("mid_pre");
        do_reset(pd, qd);
        check_int("mid_dout_before_reset", int'(pd), 1);
        check_int("mid_dout_after_reset", int'(qd), 0);
        tx_q.delete(); tx_t.delete();
        tx_q.push_back(24'h0F0F0F); tx_t.push_back(3);
        run(1400);
        check_int("mid_restart", first_high(0), RC);
        check_model("mid_post");
    endtask

    task automatic test_random();
        logic pd, qd;
        int t, gap;
        for (int it = 0; it < 2; it++) begin
            tx_q.delete(); tx_t.delete();
            t = 0;
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(0, 3))
                    0:       gap = 0;
                    1:       gap = $urandom_range(100, 470);
                    2:       gap = $urandom_range(480, 1250);
                    default: gap = $urandom_range(1300, 1600);
                endcase
                t += gap;
                tx_q.push_back(24'($urandom));
                tx_t.push_back(t);
            end
            do_reset(pd, qd);
            run(t + 6 * (PIX + RC) + 200);
            check_int("random_accepts", acc_t.size(), 6);
            check_model("random");
        end
    endtask

`ifdef WS2811_PIXCNT_EN
    task automatic test_pix_count();
        logic pd, qd;
        int mx;
        tx_q.delete(); tx_t.delete();
        for (int k = 0; k < 5; k++) begin
            tx_q.push_back(24'($urandom));
            tx_t.push_back(0);
        end
        do_reset(pd, qd);
        run(4100);
        mx = 0;
        foreach (tr_p[i]) if (int'(tr_p[i]) > mx) mx = int'(tr_p[i]);
        check_int("pixcnt_max", mx, 5);
        check_int("pixcnt_before_latch_end", int'(tr_p[RC + 5 * PIX + RC - 1]), 5);
        check_int("pixcnt_at_latch_end", int'(tr_p[RC + 5 * PIX + RC]), 0);
        check_model("pixcnt");
    endtask
`endif

    initial begin
        pix.in_valid = 1'b0;
        pix.in_data  = '0;
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_accept_during_latch();
        test_reset_mid_pixel();
        test_random();
`ifdef WS2811_PIXCNT_EN
        test_pix_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
